// File: rtl/seq_restoring_div.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIV_BCD_OUT_EN to add a double-dabble stage that also presents the results as packed BCD.
module seq_restoring_div #(
  parameter int unsigned W          = 8,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [W-1:0]            dividend,
  input  logic [W-1:0]            divisor,
  output logic                    busy,
  output logic                    done,
  output logic [W-1:0]            quotient,
  output logic [W-1:0]            remainder,
`ifdef DIV_BCD_OUT_EN
  output logic [4*BCD_DIGITS-1:0] q_bcd,
  output logic [4*BCD_DIGITS-1:0] r_bcd,
`endif
  output logic                    div_zero
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(W - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StConv, StFin} state_e;

`ifdef DIV_BCD_OUT_EN
  localparam state_e StAfterDiv = StConv;
`else
  localparam state_e StAfterDiv = StFin;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    b_q;
  logic [W:0]      p_q;
  logic [W-1:0]    q_q;
  logic            zero_q;
  logic            done_q;
  logic [W-1:0]    quotient_q, remainder_q;
  logic            div_zero_q;
  logic [W:0]      trial;
  logic            accept;

  // The done cycle is already back in IDLE, so a start held across it must wait one more cycle.
  assign accept = (state_q == StIdle) && start && !done_q;
  assign trial  = {p_q[W-1:0], q_q[W-1]} - {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StDiv;
      // A zero divisor is detected on the captured operand and skips all iterations.
      StDiv:  if (b_q == '0 || cnt_q == '0) state_d = StAfterDiv;
      StConv: if (cnt_q == '0) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef DIV_BCD_OUT_EN
  logic [4*BCD_DIGITS-1:0] qb_q, rb_q, q_bcd_q, r_bcd_q;

  function automatic logic [4*BCD_DIGITS-1:0] dd_step(input logic [4*BCD_DIGITS-1:0] bcd,
                                                      input logic bit_in);
    logic [4*BCD_DIGITS-1:0] b;
    b = bcd;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (b[4*i+:4] >= 4'd5) b[4*i+:4] = b[4*i+:4] + 4'd3;
    end
    return {b[4*BCD_DIGITS-2:0], bit_in};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qb_q    <= '0;
      rb_q    <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            qb_q <= '0;
            rb_q <= '0;
          end
        end
        StConv: begin
          qb_q <= dd_step(qb_q, q_q[cnt_q]);
          rb_q <= dd_step(rb_q, p_q[cnt_q]);
        end
        StFin: begin
          q_bcd_q <= zero_q ? {BCD_DIGITS{4'h9}} : qb_q;
          r_bcd_q <= rb_q;
        end
        default: ;
      endcase
    end
  end

  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      b_q         <= '0;
      p_q         <= '0;
      q_q         <= '0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            b_q    <= divisor;
            p_q    <= '0;
            q_q    <= dividend;
            cnt_q  <= CntLoad;
            zero_q <= 1'b0;
          end
        end
        StDiv: begin
          if (b_q == '0) begin
            p_q    <= {1'b0, q_q};
            q_q    <= '1;
            zero_q <= 1'b1;
            cnt_q  <= CntLoad;
          end else begin
            if (!trial[W]) begin
              p_q <= trial;
              q_q <= {q_q[W-2:0], 1'b1};
            end else begin
              p_q <= {p_q[W-1:0], q_q[W-1]};
              q_q <= {q_q[W-2:0], 1'b0};
            end
            // Reload on the last iteration so the conversion stage starts with a full count.
            cnt_q <= (cnt_q == '0) ? CntLoad : cnt_q - 1'b1;
          end
        end
        StConv: cnt_q <= cnt_q - 1'b1;
        StFin: begin
          done_q      <= 1'b1;
          quotient_q  <= q_q;
          remainder_q <= p_q[W-1:0];
          div_zero_q  <= zero_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Scoreboard bench for seq_restoring_div: directed vectors push expectations, a monitor checks each done.
module tb_seq_restoring_div;
  localparam int unsigned W = 8;
`ifdef DIV_BCD_OUT_EN
  localparam int LAT  = 2 * W + 1;
  localparam int LATZ = W + 2;
`else
  localparam int LAT  = W + 1;
  localparam int LATZ = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;
`ifdef DIV_BCD_OUT_EN
  logic [11:0]  q_bcd, r_bcd;
`endif

  seq_restoring_div #(.W(W), .BCD_DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef DIV_BCD_OUT_EN
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
`endif
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic [11:0]  qb;
    logic [11:0]  rb;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: counts edges and checks every done pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 at cycle %0d required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_zero", 32'(div_zero), 32'(e.z));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_at_done", 32'(busy), 32'd0);
`ifdef DIV_BCD_OUT_EN
          chk("q_bcd", 32'(q_bcd), 32'(e.qb));
          chk("r_bcd", 32'(r_bcd), 32'(e.rb));
`endif
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                      input logic [11:0] qb, input logic [11:0] rb, input int done_cyc);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.qb = qb; e.rb = rb; e.cyc = done_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int n0, input string name);
    for (int i = 0; i < 60 && n_done == n0; i++) @(negedge clk);
    if (n_done == n0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done required a done pulse", name);
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                     input logic [W-1:0] r, input logic z, input logic [11:0] qb,
                     input logic [11:0] rb, input string name);
    int n0;
    @(negedge clk);
    n0 = n_done;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push(q, r, z, qb, rb, cyc + 1 + ((b == 0) ? LATZ : LAT));
    @(negedge clk);
    start    = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    // Scramble inputs after acceptance; they must not matter.
    dividend = ~a;
    divisor  = b ^ 8'h5A;
    wait_done(n0, name);
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);

    run(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 12'h028, 12'h004, "d200_7");
    run(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 12'h255, 12'h000, "d255_1");
    run(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 12'h000, 12'h005, "d5_9");
    run(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 12'h000, 12'h000, "d0_3");
    run(8'd123, 8'd0,   8'hFF,  8'd123, 1'b1, 12'h999, 12'h123, "d123_0");
    run(8'd17,  8'd17,  8'd1,   8'd0,   1'b0, 12'h001, 12'h000, "d17_17");
    run(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 12'h000, 12'h254, "d254_255");

    // Second start while busy is ignored.
    @(negedge clk);
    n0 = n_done;
    dividend = 8'd100; divisor = 8'd3; start = 1'b1;
    push(8'd33, 8'd1, 1'b0, 12'h033, 12'h001, cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, "busy_start");
    repeat (LAT + 4) @(negedge clk);

    // Start held across done is accepted one cycle after the done cycle.
    @(negedge clk);
    n0 = n_done;
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    push(8'd28, 8'd4, 1'b0, 12'h028, 12'h004, cyc + 1 + LAT);
    push(8'd28, 8'd4, 1'b0, 12'h028, 12'h004, cyc + 1 + 2 * LAT + 2);
    wait_done(n0, "held_first");
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(n0 + 1, "held_second");

    // Reset mid-operation: abort, no done pulse, outputs cleared.
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done", 32'(done), 32'd0);
    repeat (LAT + 4) @(negedge clk);
    run(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 12'h028, 12'h004, "after_rst");

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
